// File: rtl/n25q_spi_responder.sv
// n25q_spi_responder
//   SPI-flash responder emulating the N25Q command subset (READ ID, READ
//   STATUS, WREN, WRDI, READ, PAGE PROGRAM, BULK ERASE) on a mode-0 link.
//   The link pins are oversampled by ifclk; commands are served from an
//   internal 2**ADDR_WIDTH byte array.
//
// Ports
//   ifclk    in   system clock, all state on its rising edge
//   resetb   in   synchronous active-low reset
//   sclk     in   SPI clock from host (asynchronous to ifclk)
//   csb      in   chip select, active low
//   mosi     in   host-to-device data
//   miso     out  device-to-host data (0 whenever miso_oe is 0)
//   miso_oe  out  high while the device drives miso
//   wip      out  write in progress (status bit 0)
//   wel      out  write enable latch (status bit 1)
module n25q_spi_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
  parameter int          PROG_CYCLES = 64
) (
  input  logic ifclk,
  input  logic resetb,
  input  logic sclk,
  input  logic csb,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic wip,
  output logic wel
);

  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_BE   = 8'hC7;

  localparam int CNT_W = (ADDR_WIDTH > $clog2(PROG_CYCLES)) ? ADDR_WIDTH : $clog2(PROG_CYCLES);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(2**ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_ADDR, S_DOUT, S_DIN, S_IGNORE
  } state_t;

  // Action armed by the opcode, committed on csb rise
  typedef enum logic [2:0] {
    P_NONE, P_WREN, P_WRDI, P_PROG, P_ERASE
  } pend_t;

  state_t state, state_nxt;
  pend_t  pend;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic csb_p0, csb_p1, csb_p2;
  logic mosi_p0, mosi_p1;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  logic [2:0]            bit_cnt;
  logic [3:0]            tot_bits;
  logic [1:0]            addr_cnt;
  logic [2:0]            out_cnt;
  logic [1:0]            id_idx;
  logic [7:0]            cmd;
  logic [CNT_W-1:0]      busy_cnt;
  logic                  erasing;

  logic [7:0]            sr_in;
  logic [7:0]            sr_out;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            mem [0:2**ADDR_WIDTH-1];

  logic [7:0]            byte_val;
  logic                  byte_done;
  logic [7:0]            dout_byte;
  logic                  prog_we;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous value for
  // edge detection. Not reset so that a csb already low at reset release
  // does not look like a falling edge.
  always_ff @(posedge ifclk) begin
    sclk_p0 <= sclk;
    sclk_p1 <= sclk_p0;
    sclk_p2 <= sclk_p1;
    csb_p0  <= csb;
    csb_p1  <= csb_p0;
    csb_p2  <= csb_p1;
    mosi_p0 <= mosi;
    mosi_p1 <= mosi_p0;
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign csb_rise  = csb_p1 & ~csb_p2;
  assign csb_fall  = ~csb_p1 & csb_p2;

  // Stage p2: byte assembly and decode (mosi_p1 is aligned with sclk_p1)
  assign byte_val  = {sr_in[6:0], mosi_p1};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != S_IDLE);
  assign prog_we   = byte_done && (state == S_DIN) && !csb_rise && !csb_fall;

  always_comb begin
    dout_byte = 8'h00;
    case (cmd)
      OP_RDID: begin
        case (id_idx)
          2'd0:    dout_byte = JEDEC_ID[23:16];
          2'd1:    dout_byte = JEDEC_ID[15:8];
          2'd2:    dout_byte = JEDEC_ID[7:0];
          default: dout_byte = 8'h00;
        endcase
      end
      OP_RDSR: dout_byte = {6'b0, wel, wip};
      OP_READ: dout_byte = mem[addr];
      default: dout_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (csb_rise) begin
      state_nxt = S_IDLE;
    end else if (csb_fall) begin
      state_nxt = S_OPCODE;
    end else if (byte_done) begin
      case (state)
        S_OPCODE: begin
          if (wip) begin
            state_nxt = (byte_val == OP_RDSR) ? S_DOUT : S_IGNORE;
          end else begin
            case (byte_val)
              OP_RDID, OP_RDSR: state_nxt = S_DOUT;
              OP_READ:          state_nxt = S_ADDR;
              OP_PP:            state_nxt = wel ? S_ADDR : S_IGNORE;
              default:          state_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (addr_cnt == 2'd2) begin
            state_nxt = (cmd == OP_READ) ? S_DOUT : S_DIN;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge ifclk) begin
    if (!resetb) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p3: control registers and outputs
  always_ff @(posedge ifclk) begin
    if (!resetb) begin
      bit_cnt  <= '0;
      tot_bits <= '0;
      addr_cnt <= '0;
      out_cnt  <= '0;
      id_idx   <= '0;
      cmd      <= '0;
      pend     <= P_NONE;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      wip      <= 1'b0;
      wel      <= 1'b0;
      busy_cnt <= '0;
      erasing  <= 1'b0;
    end else begin
      if (wip) begin
        if (busy_cnt == (erasing ? ERASE_LAST : PROG_LAST)) begin
          wip      <= 1'b0;
          wel      <= 1'b0;
          erasing  <= 1'b0;
          busy_cnt <= '0;
        end else begin
          busy_cnt <= busy_cnt + CNT_W'(1);
        end
      end

      if (csb_rise) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        pend    <= P_NONE;
        case (pend)
          P_WREN:  if (state == S_IGNORE && tot_bits == 4'd8) wel <= 1'b1;
          P_WRDI:  if (state == S_IGNORE && tot_bits == 4'd8) wel <= 1'b0;
          P_ERASE: begin
            if (state == S_IGNORE && tot_bits == 4'd8) begin
              wip      <= 1'b1;
              erasing  <= 1'b1;
              busy_cnt <= '0;
            end
          end
          // A complete address is required; partial data bytes are dropped
          P_PROG: begin
            if (state == S_DIN) begin
              wip      <= 1'b1;
              erasing  <= 1'b0;
              busy_cnt <= '0;
            end
          end
          default: ;
        endcase
      end else if (csb_fall) begin
        bit_cnt  <= '0;
        tot_bits <= '0;
        addr_cnt <= '0;
        out_cnt  <= '0;
        id_idx   <= '0;
        pend     <= P_NONE;
        miso     <= 1'b0;
        miso_oe  <= 1'b0;
      end else if (state != S_IDLE) begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (tot_bits != 4'hF) tot_bits <= tot_bits + 4'd1;
        end
        if (byte_done) begin
          case (state)
            S_OPCODE: begin
              cmd <= byte_val;
              if (wip) begin
                pend <= P_NONE;
              end else begin
                case (byte_val)
                  OP_WREN: pend <= P_WREN;
                  OP_WRDI: pend <= P_WRDI;
                  OP_BE:   pend <= wel ? P_ERASE : P_NONE;
                  OP_PP:   pend <= wel ? P_PROG : P_NONE;
                  default: pend <= P_NONE;
                endcase
              end
            end
            S_ADDR:  addr_cnt <= addr_cnt + 2'd1;
            default: ;
          endcase
        end
        if (sclk_fall && state == S_DOUT) begin
          miso_oe <= 1'b1;
          out_cnt <= out_cnt + 3'd1;
          if (out_cnt == 3'd0) begin
            miso <= dout_byte[7];
            if (cmd == OP_RDID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
          end else begin
            miso <= sr_out[7];
          end
        end
      end
    end
  end

  // Stage p3: data path (shift registers and address), not reset
  always_ff @(posedge ifclk) begin
    if (sclk_rise) sr_in <= byte_val;
    if (byte_done && !csb_rise && !csb_fall) begin
      if (state == S_ADDR) begin
        addr <= ADDR_WIDTH'({addr, byte_val});
      end else if (state == S_DIN) begin
        // Program address wraps inside the 256-byte page
        addr <= {addr[ADDR_WIDTH-1:8], addr[7:0] + 8'd1};
      end
    end
    if (sclk_fall && state == S_DOUT && !csb_rise && !csb_fall) begin
      if (out_cnt == 3'd0) begin
        sr_out <= {dout_byte[6:0], 1'b0};
        if (cmd == OP_READ) addr <= addr + ADDR_WIDTH'(1);
      end else begin
        sr_out <= {sr_out[6:0], 1'b0};
      end
    end
  end

  // Array: erase sweeps one location per cycle; programming can only clear bits
  always_ff @(posedge ifclk) begin
    if (erasing) begin
      mem[busy_cnt[ADDR_WIDTH-1:0]] <= 8'hFF;
    end else if (prog_we) begin
      mem[addr] <= mem[addr] & byte_val;
    end
  end

endmodule

// File: tb/tb_n25q_spi_responder.sv
// Testbench for n25q_spi_responder: drives mode-0 SPI transactions from a
// host model and checks status, program, erase and read-back behaviour.
module tb_n25q_spi_responder;

  logic ifclk = 1'b0;
  logic resetb = 1'b0;
  logic sclk = 1'b0;
  logic csb = 1'b0;
  logic mosi = 1'b0;
  logic miso, miso_oe, wip, wel;

  localparam int H = 6;

  int n_checks = 0;
  int n_pass = 0;
  int wip_cycles = 0;

  typedef struct {
    string       name;
    logic [7:0]  op;
    bit          has_addr;
    logic [23:0] addr;
    int          n;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  n25q_spi_responder #(
    .ADDR_WIDTH (10),
    .JEDEC_ID   (24'h20BA18),
    .PROG_CYCLES(64)
  ) dut (
    .ifclk  (ifclk),
    .resetb (resetb),
    .sclk   (sclk),
    .csb    (csb),
    .mosi   (mosi),
    .miso   (miso),
    .miso_oe(miso_oe),
    .wip    (wip),
    .wel    (wel)
  );

  always #5 ifclk = ~ifclk;

  always @(negedge ifclk) if (wip) wip_cycles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ifclk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      cyc(H);
      rx[i] = miso;
      sclk = 1'b1;
      cyc(H);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    sclk = 1'b0;
    csb  = 1'b0;
    cyc(H);
  endtask

  task automatic cs_hi();
    cyc(H);
    csb  = 1'b1;
    mosi = 1'b0;
    cyc(10);
  endtask

  task automatic xact(input logic [7:0] op, input bit has_addr, input logic [23:0] addr,
                      input int n_in, input logic [31:0] wdata, input int n_out,
                      output logic [31:0] rdata);
    logic [7:0] b;
    rdata = 32'h0;
    cs_lo();
    spi_bits(op, 8, b);
    if (has_addr) begin
      spi_bits(addr[23:16], 8, b);
      spi_bits(addr[15:8], 8, b);
      spi_bits(addr[7:0], 8, b);
    end
    for (int i = 0; i < n_in; i++) spi_bits(wdata[31-8*i -: 8], 8, b);
    for (int i = 0; i < n_out; i++) begin
      spi_bits(8'h00, 8, b);
      rdata[31-8*i -: 8] = b;
    end
    if (n_out > 0) check("miso_oe while reading", 32'(miso_oe), 32'h1);
    cs_hi();
    if (n_out > 0) check("miso released after csb", 32'({miso_oe, miso}), 32'h0);
  endtask

  task automatic cmd(input logic [7:0] op);
    logic [31:0] d;
    xact(op, 1'b0, 24'h0, 0, 32'h0, 0, d);
  endtask

  task automatic wait_wip_low(input string name, input int limit);
    for (int i = 0; i < limit && wip; i++) cyc(1);
    check(name, 32'(wip), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          w0;

    vecs[0] = '{"read id",            8'h9F, 1'b0, 24'h000000, 4, 32'h20BA1800};
    vecs[1] = '{"status idle",        8'h05, 1'b0, 24'h000000, 1, 32'h00000000};
    vecs[2] = '{"read FE page data",  8'h03, 1'b1, 24'h0000FE, 3, 32'hA55AFF00};
    vecs[3] = '{"read 000 page wrap", 8'h03, 1'b1, 24'h000000, 1, 32'h3C000000};
    vecs[4] = '{"read 010 no wel",    8'h03, 1'b1, 24'h000010, 1, 32'hFF000000};
    vecs[5] = '{"read 020 and",       8'h03, 1'b1, 24'h000020, 1, 32'h00000000};
    vecs[6] = '{"read 3FF wrap",      8'h03, 1'b1, 24'h0003FF, 2, 32'hFF3C0000};
    vecs[7] = '{"read upper ignored", 8'h03, 1'b1, 24'hABC0FE, 2, 32'hA55A0000};

    // Reset with csb low and sclk toggling
    resetb = 1'b0;
    csb    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      cyc(1);
    end
    check("reset miso",    32'(miso),    32'h0);
    check("reset miso_oe", 32'(miso_oe), 32'h0);
    check("reset wip",     32'(wip),     32'h0);
    check("reset wel",     32'(wel),     32'h0);
    sclk   = 1'b0;
    resetb = 1'b1;
    cyc(4);

    // csb already low: a WREN here must be ignored
    spi_bits(8'h06, 8, b);
    check("no oe before new csb fall", 32'(miso_oe), 32'h0);
    cs_hi();
    check("no wel before new csb fall", 32'(wel), 32'h0);

    // Bulk erase with status polling
    cmd(8'h06);
    check("wel after wren", 32'(wel), 32'h1);
    xact(8'h05, 1'b0, 24'h0, 0, 32'h0, 1, rd);
    check("status after wren", 32'(rd[31:24]), 32'h02);
    w0 = wip_cycles;
    cmd(8'hC7);
    xact(8'h05, 1'b0, 24'h0, 0, 32'h0, 1, rd);
    check("status during erase", 32'(rd[31:24]), 32'h03);
    wait_wip_low("erase completes", 3000);
    check("erase wip cycles", 32'(wip_cycles - w0), 32'd1024);
    check("wel after erase", 32'(wel), 32'h0);
    xact(8'h03, 1'b1, 24'h000000, 0, 32'h0, 2, rd);
    check("erase readback", rd, 32'hFFFF0000);

    // WRDI clears wel
    cmd(8'h06);
    cmd(8'h04);
    check("wel after wrdi", 32'(wel), 32'h0);

    // Page program across page end
    cmd(8'h06);
    w0 = wip_cycles;
    xact(8'h02, 1'b1, 24'h0000FE, 3, 32'hA55A3C00, 0, rd);
    check("wip during program", 32'(wip), 32'h1);
    wait_wip_low("program completes", 500);
    check("program wip cycles", 32'(wip_cycles - w0), 32'd64);
    check("wel after program", 32'(wel), 32'h0);

    // Program with wel=0 is ignored
    xact(8'h02, 1'b1, 24'h000010, 1, 32'h00000000, 0, rd);
    check("wip after program without wel", 32'(wip), 32'h0);

    // Program can only clear bits
    cmd(8'h06);
    xact(8'h02, 1'b1, 24'h000020, 1, 32'h0F000000, 0, rd);
    wait_wip_low("program 0F completes", 500);
    cmd(8'h06);
    xact(8'h02, 1'b1, 24'h000020, 1, 32'hF0000000, 0, rd);
    wait_wip_low("program F0 completes", 500);

    // Partial WREN (5 bits) leaves wel clear
    cs_lo();
    spi_bits(8'h06, 5, b);
    cs_hi();
    check("wel after partial wren", 32'(wel), 32'h0);

    // Read-back table
    for (int i = 0; i < 8; i++) begin
      xact(vecs[i].op, vecs[i].has_addr, vecs[i].addr, 0, 32'h0, vecs[i].n, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/n25q_spi_responder.md
# n25q_spi_responder

Synthesizable SPI-flash responder emulating the N25Q command subset used by the N25Q host controller: it sits on the far end of the `sclk`/`csb`/`mosi`/`miso` link, decodes mode-0 SPI commands and serves reads and programs from an internal byte array. It is used as a loopback target on FPGA test builds and as the bench-side flash model, so that the host controller and the `spi_master` can be exercised without a physical part.

## Interface
- `ADDR_WIDTH`, 10: internal array is 2**ADDR_WIDTH bytes; the upper address bits received on the link are ignored.
- `JEDEC_ID`, 24'h20BA18: the three bytes returned by READ ID, MSB first.
- `PROG_CYCLES`, 64: number of `ifclk` cycles that WIP stays high after a PAGE PROGRAM.
- `ifclk` input 1: the single clock; all state is on its rising edge.
- `resetb` input 1: synchronous, active-low reset.
- `sclk` input 1: SPI clock from the host, asynchronous to `ifclk`.
- `csb` input 1: chip select, active low.
- `mosi` input 1: host-to-device serial data.
- `miso` output 1: device-to-host serial data.
- `miso_oe` output 1: high while the device is driving `miso`; used for the top-level tristate.
- `wip` output 1: write-in-progress, mirrors status bit 0.
- `wel` output 1: write-enable latch, mirrors status bit 1.

## Operation
- `sclk`, `csb` and `mosi` each pass through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized copies. SPI mode 0: `mosi` is sampled on `sclk` rise and `miso` is updated on `sclk` fall.
- A falling edge on `csb` starts a transaction with bit_cnt=0 and state OPCODE. A rising edge on `csb` returns the block to IDLE from any state and commits any pending action.
- Bytes are received MSB first. Eight sampled bits complete a byte.
- States: IDLE, OPCODE, ADDR (3 bytes), DOUT, DIN, IGNORE.
- 0x9F READ ID: go to DOUT. Send JEDEC_ID[23:16], then [15:8], then [7:0], then 0x00 for every following byte.
- 0x05 READ STATUS: go to DOUT. Send {6'b0, wel, wip}, re-sampled at the start of each byte.
- 0x06 WREN / 0x04 WRDI: go to IGNORE. On `csb` rise, set (WREN) or clear (WRDI) `wel`, but only if exactly 8 bits were received.
- 0x03 READ: go to ADDR, then DOUT. Data comes from mem[addr], and addr increments after each byte, wrapping modulo 2**ADDR_WIDTH.
- 0x02 PAGE PROGRAM, with wel=1 and wip=0: go to ADDR, then DIN.
  - Each complete byte does mem[addr] <= mem[addr] & byte (program can only clear bits).
  - Only addr[7:0] increments (256-byte page wrap).
  - On `csb` rise: wip=1 for PROG_CYCLES cycles, then wip=0 and wel=0.
- 0xC7 BULK ERASE, with wel=1 and wip=0: on `csb` rise after exactly 8 bits, set wip=1. An erase counter then writes 0xFF to one location per `ifclk` cycle from 0 to 2**ADDR_WIDTH-1. After the last location, wip=0 and wel=0.
- While wip=1, every opcode except 0x05 goes to IGNORE with no side effects.
- PROGRAM or ERASE with wel=0, and any unknown opcode, go to IGNORE.
- A partial byte at `csb` rise is discarded. A partial address aborts the command with no write.
- Array contents are not affected by reset. After power-up, contents are undefined until a BULK ERASE.

## Timing
- Reset values: miso=0, miso_oe=0, wip=0, wel=0, state=IDLE. The program/erase counter is cleared, which abandons any erase in progress.
- After reset, a transaction starts only on a new `csb` falling edge. If `csb` is already low, the block stays in IDLE until `csb` rises and falls again.
- Input latency: 3 `ifclk` cycles from a pin edge to the synchronized edge pulse.
- `miso` changes no later than 4 `ifclk` cycles after the `sclk` falling pin edge. The MSB of the first output byte is driven on the falling edge that follows the last opcode or address bit.
- Supported `sclk` rate: `sclk` high and low each last at least 4 `ifclk` cycles, i.e. clk_divider ≥ 4 on the host side.
- `miso_oe` is 1 only in DOUT, from the first output falling edge until `csb` rise (+3 cycles). `miso` is 0 whenever `miso_oe` is 0.
- `wip` and `wel` update in the cycle after the synchronized `csb` rising edge. Bulk erase takes exactly 2**ADDR_WIDTH cycles of wip=1.

## Test plan
- Reset held for 4 cycles with `csb` low and `sclk` toggling: miso=0, miso_oe=0, wip=0, wel=0. There is no response until `csb` rises and falls again.
- READ ID (0x9F, then 32 clocks): received bytes are 0x20, 0xBA, 0x18, 0x00.
- Sequence 0x06; 0x05 (1 byte); 0xC7; 0x05 polled: status reads 0x02, then 0x03, and wip stays high for exactly 1024 cycles. Afterwards, 0x03 from 0x000000 reads 0xFF.
- Sequence 0x06; 0x02 at address 0x0000FE with data 0xA5, 0x5A, 0x3C; wait for wip=0; 0x03 from 0x0000FE for 3 bytes: reads 0xA5, 0x5A, 0xFF, and mem[0x000] reads 0x3C (page wrap). wel=0 afterwards.
- 0x02 with wel=0 at address 0x000010 with data 0x00: mem[0x010] is unchanged (0xFF) and wip stays 0. A further program of 0xF0 over 0x0F gives 0x00 (AND behaviour).
- 0x06 followed by `csb` rise after 5 bits: wel stays 0. A READ at 0x0003FF for 2 bytes wraps to address 0x000.
